fabric_cfg_loader: RTL and testbench



---
 rtl/fabric_cfg_pkg.sv | 46 ++++
 rtl/cfg_width_check.sv | 13 +
 rtl/fabric_cfg_loader.sv | 114 +++++++++++
 tb/tb_fabric_cfg_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared definitions for the fabric configuration path: image word map,
// loader states and the per-word legal-width rule.
package fabric_cfg_pkg;

    localparam int NUM_CFG_WORDS = 15;
    localparam int CFG_DATA_W    = 32;

    localparam logic [3:0] IDX_ADD0_LUT = 4'd0;
    localparam logic [3:0] IDX_ADD0_MUX = 4'd1;
    localparam logic [3:0] IDX_ADD1_LUT = 4'd2;
    localparam logic [3:0] IDX_ADD1_MUX = 4'd3;
    localparam logic [3:0] IDX_ADDC_LUT = 4'd4;
    localparam logic [3:0] IDX_ADDC_MUX = 4'd5;
    localparam logic [3:0] IDX_MUX_LUT  = 4'd6;
    localparam logic [3:0] IDX_MUX_MUX  = 4'd7;
    localparam logic [3:0] IDX_MUXS_LUT = 4'd8;
    localparam logic [3:0] IDX_MUXS_MUX = 4'd9;
    localparam logic [3:0] IDX_REGC_LUT = 4'd10;
    localparam logic [3:0] IDX_REGC_MUX = 4'd11;
    localparam logic [3:0] IDX_SB0      = 4'd12;
    localparam logic [3:0] IDX_SB12     = 4'd13;
    localparam logic [3:0] IDX_SB3      = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } cfg_state_t;

    // Mux-control words carry a single select bit, switch-box words 16 bits,
    // LUT words use the full width. Indices past the image are never legal.
    function automatic logic cfg_word_legal(input logic [3:0] idx,
                                            input logic [CFG_DATA_W-1:0] data);
        logic legal;
        legal = 1'b1;
        if (idx > IDX_SB3)
            legal = 1'b0;
        else if (idx >= IDX_SB0)
            legal = (data[CFG_DATA_W-1:16] == '0);
        else if (idx[0])
            legal = (data[CFG_DATA_W-1:1] == '0);
        return legal;
    endfunction

endpackage

// File: rtl/cfg_width_check.sv
// Combinational legality check for one configuration word at a given image
// index; kept separate so a readback block can reuse it.
module cfg_width_check
    import fabric_cfg_pkg::*;
(
    input  logic [3:0]            idx,
    input  logic [CFG_DATA_W-1:0] data,
    output logic                  legal
);

    assign legal = cfg_word_legal(idx, data);

endmodule

// File: rtl/fabric_cfg_loader.sv
// Receives the configuration image as a valid/ready word stream, issues
// registered one-hot write strobes and enables the fabric after a clean image.
module fabric_cfg_loader
    import fabric_cfg_pkg::*;
#(
    parameter int NUM_WORDS = NUM_CFG_WORDS,
    parameter int DATA_W    = CFG_DATA_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NUM_WORDS-1:0] cfg_we,
    output logic [DATA_W-1:0]    cfg_data,
    output logic                 busy,
    output logic                 commit,
    output logic                 fabric_en,
    output logic                 error,
    output logic [3:0]           word_idx
);

    cfg_state_t state;
    cfg_state_t state_next;
    logic       word_legal;
    logic       in_fire;
    logic       accept;
    logic       reject;
    logic       last_word;

    cfg_width_check u_width_check (
        .idx   (word_idx),
        .data  (in_data),
        .legal (word_legal)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (start)
                    state_next = ST_LOAD;
                else if (in_fire && !word_legal)
                    state_next = ST_ERR;
                else if (in_fire && last_word)
                    state_next = ST_DONE;
            end
            ST_DONE, ST_ERR: begin
                if (start)
                    state_next = ST_LOAD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A start pulse overrides any handshake presented in the same cycle.
    always_comb begin
        in_ready  = (state == ST_LOAD);
        busy      = (state == ST_LOAD);
        last_word = (word_idx == IDX_SB3);
        in_fire   = in_valid && in_ready && !start;
        accept    = in_fire && word_legal;
        reject    = in_fire && !word_legal;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cfg_we   <= '0;
            cfg_data <= '0;
            commit   <= 1'b0;
        end else begin
            cfg_we <= accept ? ({{(NUM_WORDS-1){1'b0}}, 1'b1} << word_idx) : '0;
            commit <= accept && last_word;
            if (accept)
                cfg_data <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            word_idx <= '0;
        else if (start)
            word_idx <= '0;
        else if (accept && !last_word)
            word_idx <= word_idx + 4'd1;
    end

    // Enable lags commit by a cycle so the final strobe has been sampled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fabric_en <= 1'b0;
            error     <= 1'b0;
        end else begin
            fabric_en <= (state == ST_DONE) && !start;
            if (start)
                error <= 1'b0;
            else if (reject)
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// Directed self-checking bench for fabric_cfg_loader: full loads, illegal
// words, valid gaps, restart mid-image and asynchronous reset mid-image.
module tb_fabric_cfg_loader;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] cfg_we;
    logic [31:0] cfg_data;
    logic        busy;
    logic        commit;
    logic        fabric_en;
    logic        error;
    logic [3:0]  word_idx;

    int          errors;
    int          checks;
    logic [31:0] image [15];

    fabric_cfg_loader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cfg_we    (cfg_we),
        .cfg_data  (cfg_data),
        .busy      (busy),
        .commit    (commit),
        .fabric_en (fabric_en),
        .error     (error),
        .word_idx  (word_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_cfg_we"}, 32'(cfg_we), 32'd0);
        checkOutput({tag, "_cfg_data"}, cfg_data, 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_commit"}, 32'(commit), 32'd0);
        checkOutput({tag, "_fabric_en"}, 32'(fabric_en), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_word_idx"}, 32'(word_idx), 32'd0);
    endtask

    task automatic applyStimulus_start();
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("start_in_ready", 32'(in_ready), 32'd1);
        checkOutput("start_busy", 32'(busy), 32'd1);
        checkOutput("start_word_idx", 32'(word_idx), 32'd0);
        checkOutput("start_error", 32'(error), 32'd0);
        checkOutput("start_fabric_en", 32'(fabric_en), 32'd0);
        checkOutput("start_cfg_we", 32'(cfg_we), 32'd0);
    endtask

    // Sends image words first..last, with up to gap_max idle cycles before each.
    task automatic applyStimulus_words(input int first, input int last, input int gap_max);
        for (int i = first; i <= last; i++) begin
            int gaps;
            gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0;
                step();
                checkOutput("gap_word_idx", 32'(word_idx), 32'(i));
                checkOutput("gap_cfg_we", 32'(cfg_we), 32'd0);
                if (i > first)
                    checkOutput("gap_cfg_data_hold", cfg_data, image[i-1]);
            end
            in_valid = 1'b1;
            in_data  = image[i];
            step();
            in_valid = 1'b0;
            checkOutput($sformatf("we_%0d", i), 32'(cfg_we), 32'(15'd1 << i));
            checkOutput($sformatf("data_%0d", i), cfg_data, image[i]);
            checkOutput($sformatf("idx_%0d", i), 32'(word_idx), (i < 14) ? 32'(i + 1) : 32'd14);
            checkOutput($sformatf("commit_%0d", i), 32'(commit), (i == 14) ? 32'd1 : 32'd0);
            checkOutput($sformatf("fabric_en_%0d", i), 32'(fabric_en), 32'd0);
        end
    endtask

    task automatic checkOutput_done();
        checkOutput("done_in_ready", 32'(in_ready), 32'd0);
        checkOutput("done_busy", 32'(busy), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        step();
        checkOutput("done_commit_pulse", 32'(commit), 32'd0);
        checkOutput("done_fabric_en", 32'(fabric_en), 32'd1);
        checkOutput("done_cfg_we", 32'(cfg_we), 32'd0);
        step();
        in_valid = 1'b0;
        checkOutput("done_fabric_en_hold", 32'(fabric_en), 32'd1);
        checkOutput("done_word_idx", 32'(word_idx), 32'd14);
        checkOutput("done_cfg_we_2", 32'(cfg_we), 32'd0);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        reset_n  = 1'b0;

        image[0]  = 32'hFFFF_FFFF;
        image[1]  = 32'h0000_0001;
        image[2]  = 32'h6996_0F0F;
        image[3]  = 32'h0000_0000;
        image[4]  = 32'hE8E8_1234;
        image[5]  = 32'h0000_0001;
        image[6]  = 32'hCACA_CACA;
        image[7]  = 32'h0000_0000;
        image[8]  = 32'h1357_9BDF;
        image[9]  = 32'h0000_0001;
        image[10] = 32'hAAAA_5555;
        image[11] = 32'h0000_0000;
        image[12] = 32'h0000_FFFF;
        image[13] = 32'h0000_1234;
        image[14] = 32'h0000_A5C3;

        #12;
        checkAllZero("reset");
        reset_n = 1'b1;
        step();
        step();
        checkOutput("idle_in_ready", 32'(in_ready), 32'd0);

        // Full load with in_valid held high.
        applyStimulus_start();
        applyStimulus_words(0, 14, 0);
        checkOutput_done();

        // Illegal mux word at index 1; start in DONE also drops fabric_en.
        applyStimulus_start();
        applyStimulus_words(0, 0, 0);
        in_valid = 1'b1;
        in_data  = 32'h0000_0002;
        step();
        checkOutput("mux_err_cfg_we", 32'(cfg_we), 32'd0);
        checkOutput("mux_err_error", 32'(error), 32'd1);
        checkOutput("mux_err_in_ready", 32'(in_ready), 32'd0);
        checkOutput("mux_err_word_idx", 32'(word_idx), 32'd1);
        step();
        step();
        in_valid = 1'b0;
        checkOutput("mux_err_cfg_we_2", 32'(cfg_we), 32'd0);
        checkOutput("mux_err_error_sticky", 32'(error), 32'd1);
        checkOutput("mux_err_fabric_en", 32'(fabric_en), 32'd0);

        // Oversized switch-box word at index 12.
        applyStimulus_start();
        applyStimulus_words(0, 11, 0);
        in_valid = 1'b1;
        in_data  = 32'h0001_FFFF;
        step();
        in_valid = 1'b0;
        checkOutput("sb_err_cfg_we", 32'(cfg_we), 32'd0);
        checkOutput("sb_err_error", 32'(error), 32'd1);
        checkOutput("sb_err_in_ready", 32'(in_ready), 32'd0);
        checkOutput("sb_err_commit", 32'(commit), 32'd0);

        // Load with random valid gaps.
        applyStimulus_start();
        applyStimulus_words(0, 14, 3);
        checkOutput_done();

        // Restart after word 7, with word 8 presented in the start cycle.
        applyStimulus_start();
        applyStimulus_words(0, 7, 0);
        in_valid = 1'b1;
        in_data  = image[8];
        start    = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("restart_cfg_we", 32'(cfg_we), 32'd0);
        checkOutput("restart_word_idx", 32'(word_idx), 32'd0);
        checkOutput("restart_in_ready", 32'(in_ready), 32'd1);
        checkOutput("restart_commit", 32'(commit), 32'd0);
        applyStimulus_words(0, 14, 0);
        checkOutput_done();

        // Asynchronous reset in the middle of an image.
        applyStimulus_start();
        applyStimulus_words(0, 5, 0);
        #2;
        reset_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        step();
        reset_n  = 1'b1;
        in_valid = 1'b1;
        in_data  = image[6];
        step();
        step();
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("post_reset_busy", 32'(busy), 32'd0);
        checkOutput("post_reset_cfg_we", 32'(cfg_we), 32'd0);
        checkOutput("post_reset_word_idx", 32'(word_idx), 32'd0);
        in_valid = 1'b0;
        applyStimulus_start();
        applyStimulus_words(0, 14, 1);
        checkOutput_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
